// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command responder:
//   state_t          - responder FSM states
//   CMD_* / CHR_*    - recognised command bytes (lower-case form) and line ends
//   RSP_*            - status letters returned by the query command
//   to_lower()       - folds ASCII 'A'..'Z' onto 'a'..'z', other bytes unchanged
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      RESP1  = 2'd2,
      RESP2  = 2'd3
   } state_t;

   localparam logic [7:0] CMD_RUN   = 8'h72;  // 'r'
   localparam logic [7:0] CMD_STOP  = 8'h73;  // 's'
   localparam logic [7:0] CMD_CLR   = 8'h63;  // 'c'
   localparam logic [7:0] CMD_MODE  = 8'h6D;  // 'm'
   localparam logic [7:0] CMD_QUERY = 8'h71;  // 'q'
   localparam logic [7:0] CHR_CR    = 8'h0D;
   localparam logic [7:0] CHR_LF    = 8'h0A;

   localparam logic [7:0] RSP_RUN   = 8'h52;  // 'R'
   localparam logic [7:0] RSP_STOP  = 8'h53;  // 'S'
   localparam logic [7:0] RSP_UP    = 8'h55;  // 'U'
   localparam logic [7:0] RSP_DN    = 8'h44;  // 'D'

   // Upper-case letters differ from lower-case only in bit 5.
   function automatic logic [7:0] to_lower(input logic [7:0] b);
      return ((b >= 8'h41) && (b <= 8'h5A)) ? (b | 8'h20) : b;
   endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Pops ASCII command bytes from the RX FIFO, drives the counter-control
// outputs and pushes a one- or two-byte reply into the TX FIFO.
//
// Parameters:
//   ACK_CHAR  reply to an accepted control command
//   NAK_CHAR  reply to an unknown command
//   ERR_W     width of the saturating unknown-command counter
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rx_rdata/rx_empty  RX FIFO head byte and empty flag
//   rx_rd              pop RX FIFO head this edge
//   tx_wdata/tx_wr     byte and push strobe towards the TX FIFO
//   tx_full            TX FIFO full flag
//   run_en             counter run enable (level)
//   clear              counter clear, single-cycle pulse during DECODE
//   up_down            counter direction, 0 = up, 1 = down
//   err_cnt            saturating count of unknown commands
// -----------------------------------------------------------------------------
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] ACK_CHAR = 8'h4B,
   parameter logic [7:0] NAK_CHAR = 8'h3F,
   parameter int         ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_rdata,
   input  logic             rx_empty,
   output logic             rx_rd,
   output logic [7:0]       tx_wdata,
   input  logic             tx_full,
   output logic             tx_wr,
   output logic             run_en,
   output logic             clear,
   output logic             up_down,
   output logic [ERR_W-1:0] err_cnt
);

   state_t           state_q;
   logic [7:0]       cmd_q;
   logic [7:0]       resp1_q;
   logic [7:0]       resp2_q;
   logic             two_q;      // reply has a second byte
   logic             run_en_q;
   logic             up_down_q;
   logic [ERR_W-1:0] err_q;

   logic [7:0]       cmd_lc;

   assign cmd_lc = to_lower(cmd_q);

   // FIFO strobes depend only on state and flags; reset forces them low
   // so nothing moves while rst is asserted, whatever state was left over.
   assign rx_rd = !rst && (state_q == IDLE) && !rx_empty;
   assign tx_wr = !rst && ((state_q == RESP1) || (state_q == RESP2)) && !tx_full;

   // clear must be high during the DECODE cycle itself, so it is decoded
   // from the registered command rather than registered again.
   assign clear = !rst && (state_q == DECODE) && (cmd_lc == CMD_CLR);

   always_comb begin
      tx_wdata = 8'h00;
      case (state_q)
         RESP1:   tx_wdata = resp1_q;
         RESP2:   tx_wdata = resp2_q;
         default: tx_wdata = 8'h00;
      endcase
   end

   assign run_en  = run_en_q;
   assign up_down = up_down_q;
   assign err_cnt = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cmd_q     <= 8'h00;
         resp1_q   <= 8'h00;
         resp2_q   <= 8'h00;
         two_q     <= 1'b0;
         run_en_q  <= 1'b0;
         up_down_q <= 1'b0;
         err_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!rx_empty) begin
                  cmd_q   <= rx_rdata;
                  state_q <= DECODE;
               end
            end

            DECODE: begin
               two_q   <= 1'b0;
               resp1_q <= ACK_CHAR;
               state_q <= RESP1;
               case (cmd_lc)
                  CMD_RUN:   run_en_q  <= 1'b1;
                  CMD_STOP:  run_en_q  <= 1'b0;
                  CMD_CLR:   ;  // pulse is generated combinationally
                  CMD_MODE:  up_down_q <= ~up_down_q;
                  CMD_QUERY: begin
                     // Reports the values in force at DECODE, i.e. after
                     // every earlier command has taken effect.
                     resp1_q <= run_en_q  ? RSP_RUN : RSP_STOP;
                     resp2_q <= up_down_q ? RSP_DN  : RSP_UP;
                     two_q   <= 1'b1;
                  end
                  CHR_CR, CHR_LF: state_q <= IDLE;  // silently ignored
                  default: begin
                     if (err_q != {ERR_W{1'b1}}) begin
                        err_q <= err_q + {{(ERR_W-1){1'b0}}, 1'b1};
                     end
                     resp1_q <= NAK_CHAR;
                  end
               endcase
            end

            RESP1: begin
               if (!tx_full) begin
                  state_q <= two_q ? RESP2 : IDLE;
               end
            end

            RESP2: begin
               if (!tx_full) begin
                  state_q <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Bench for uart_cmd_parser: an RX byte queue feeds the parser, a reference
// model turns every popped command into expected reply bytes and expected
// control levels, and every TX push is compared against that model.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

   localparam logic [7:0] ACK = 8'h4B;
   localparam logic [7:0] NAK = 8'h3F;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_rdata = 8'h00;
   logic       rx_empty = 1'b1;
   logic       rx_rd;
   logic [7:0] tx_wdata;
   logic       tx_full = 1'b0;
   logic       tx_wr;
   logic       run_en;
   logic       clear;
   logic       up_down;
   logic [7:0] err_cnt;

   always #5 clk = ~clk;

   uart_cmd_parser #(
      .ACK_CHAR(ACK),
      .NAK_CHAR(NAK),
      .ERR_W   (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rx_rdata(rx_rdata),
      .rx_empty(rx_empty),
      .rx_rd   (rx_rd),
      .tx_wdata(tx_wdata),
      .tx_full (tx_full),
      .tx_wr   (tx_wr),
      .run_en  (run_en),
      .clear   (clear),
      .up_down (up_down),
      .err_cnt (err_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] rxq[$];
   logic [7:0] expq[$];

   // reference model state
   bit m_run = 0;
   bit m_ud  = 0;
   int m_err = 0;
   int m_clears = 0;

   // observation bookkeeping
   int   cyc = 0;
   int   pop_cyc = -10;
   int   wr_cyc = -10;
   int   prev_wr_cyc = -10;
   int   clr_cyc = -10;
   int   clears_seen = 0;
   int   writes = 0;
   int   pops = 0;
   logic run_at_dec = 1'b0;
   logic run_at_wr = 1'b0;
   bit   rand_full = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Behaviour of one command, written from the command table.
   task automatic model_cmd(input logic [7:0] b);
      logic [7:0] c;
      c = ((b >= 8'h41) && (b <= 8'h5A)) ? (b + 8'h20) : b;
      case (c)
         8'h72: begin m_run = 1; expq.push_back(ACK); end
         8'h73: begin m_run = 0; expq.push_back(ACK); end
         8'h63: begin m_clears++; expq.push_back(ACK); end
         8'h6D: begin m_ud = !m_ud; expq.push_back(ACK); end
         8'h71: begin
            expq.push_back(m_run ? 8'h52 : 8'h53);
            expq.push_back(m_ud ? 8'h44 : 8'h55);
         end
         8'h0D, 8'h0A: ;
         default: begin
            if (m_err < 255) m_err++;
            expq.push_back(NAK);
         end
      endcase
   endtask

   task automatic drive_rx();
      rx_empty = (rxq.size() == 0);
      rx_rdata = rx_empty ? 8'h00 : rxq[0];
   endtask

   // One clock: sample at the falling edge, account for the rising edge,
   // then update the FIFO-side inputs 1 time unit after it.
   task automatic cycle();
      logic       pop, wr, clr, rn;
      logic [7:0] wb;
      @(negedge clk);
      pop = rx_rd;
      wr  = tx_wr;
      wb  = tx_wdata;
      clr = clear;
      rn  = run_en;
      if (cyc == pop_cyc + 1) run_at_dec = rn;
      @(posedge clk);
      #1;
      if (pop) begin
         check_eq("pop_nonempty", (rxq.size() != 0), 1);
         check_eq("pop_reply_done", expq.size(), 0);
         if (rxq.size() != 0) begin
            $display("cmd %02h popped at cycle %0d", rxq[0], cyc);
            model_cmd(rxq.pop_front());
         end
         pop_cyc = cyc;
         pops++;
      end
      if (wr) begin
         if (expq.size() == 0) check_eq("tx_extra", wr, 0);
         else check_eq("tx_byte", wb, expq.pop_front());
         prev_wr_cyc = wr_cyc;
         wr_cyc = cyc;
         run_at_wr = rn;
         writes++;
      end
      if (clr) begin
         clears_seen++;
         clr_cyc = cyc;
      end
      cyc++;
      if (rand_full) tx_full = ($urandom_range(99) < 30);
      drive_rx();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rxq.size() != 0 || expq.size() != 0) && n < 10000) begin
         cycle();
         n++;
      end
      check_eq("drain_done", rxq.size() + expq.size(), 0);
      repeat (4) cycle();
   endtask

   task automatic push(input logic [7:0] b);
      rxq.push_back(b);
      drive_rx();
   endtask

   initial begin
      int w0, p0, w1, w2;
      logic [7:0] pool[12];
      pool = '{8'h72, 8'h73, 8'h63, 8'h6D, 8'h71, 8'h52, 8'h53, 8'h43,
               8'h4D, 8'h51, 8'h0D, 8'h0A};

      // ---------------- reset, with both FIFOs offering work ----------------
      rst = 1'b1;
      rx_empty = 1'b0;
      rx_rdata = 8'h72;
      tx_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rx_rd", rx_rd, 0);
      check_eq("rst_tx_wr", tx_wr, 0);
      check_eq("rst_run_en", run_en, 0);
      check_eq("rst_up_down", up_down, 0);
      check_eq("rst_clear", clear, 0);
      check_eq("rst_err_cnt", err_cnt, 0);
      check_eq("rst_tx_wdata", tx_wdata, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_rx();

      // ---------------- 'r': latency of reply and run_en ----------------
      push(8'h72);
      drain();
      check_eq("r_wr_latency", wr_cyc - pop_cyc, 2);
      check_eq("r_run_at_decode", run_at_dec, 0);
      check_eq("r_run_at_reply", run_at_wr, 1);
      check_eq("r_run_en", run_en, 1);
      check_eq("r_err_cnt", err_cnt, 0);

      // ---------------- 'C': one-cycle clear during DECODE ----------------
      push(8'h43);
      drain();
      check_eq("c_clear_cycle", clr_cyc - pop_cyc, 1);
      check_eq("c_clear_count", clears_seen, m_clears);
      check_eq("c_run_en", run_en, m_run);
      check_eq("c_up_down", up_down, m_ud);

      // ---------------- 's','m','q': status reply ----------------
      push(8'h73);
      push(8'h6D);
      push(8'h71);
      drain();
      check_eq("q_up_down", up_down, 1);
      check_eq("q_bytes_back_to_back", wr_cyc - prev_wr_cyc, 1);

      // ---------------- CR, LF, 'z': only one NAK ----------------
      w0 = writes;
      push(8'h0D);
      push(8'h0A);
      push(8'h7A);
      drain();
      check_eq("crlf_one_reply", writes - w0, 1);
      check_eq("crlf_err_cnt", err_cnt, 1);

      // ---------------- TX back-pressure ----------------
      tx_full = 1'b1;
      w0 = writes;
      p0 = pops;
      push(8'h71);
      push(8'h72);
      repeat (20) cycle();
      check_eq("stall_no_write", writes - w0, 0);
      check_eq("stall_one_pop", pops - p0, 1);
      tx_full = 1'b0;
      for (int i = 0; i < 10 && writes < w0 + 2; i++) cycle();
      check_eq("stall_release_writes", writes - w0, 2);
      w1 = prev_wr_cyc;
      w2 = wr_cyc;
      check_eq("stall_consecutive", w2 - w1, 1);
      cycle();
      check_eq("stall_next_pop", pops - p0, 2);
      check_eq("stall_next_pop_cycle", pop_cyc, w2 + 1);
      drain();

      // ---------------- reset during the second reply byte ----------------
      w0 = writes;
      push(8'h71);
      for (int i = 0; i < 10 && writes < w0 + 1; i++) cycle();
      check_eq("rstq_first_byte", writes - w0, 1);
      // DUT is now in its second-byte state with the TX FIFO ready.
      rst = 1'b1;
      push(8'h72);
      @(negedge clk);
      check_eq("rstq_tx_wr", tx_wr, 0);
      check_eq("rstq_rx_rd", rx_rd, 0);
      @(negedge clk);
      check_eq("rstq_tx_wr2", tx_wr, 0);
      check_eq("rstq_run_en", run_en, 0);
      check_eq("rstq_up_down", up_down, 0);
      check_eq("rstq_err_cnt", err_cnt, 0);
      check_eq("rstq_clear", clear, 0);
      check_eq("rstq_tx_wdata", tx_wdata, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_run = 0;
      m_ud = 0;
      m_err = 0;
      m_clears = 0;
      clears_seen = 0;
      expq.delete();
      drive_rx();
      drain();
      check_eq("post_rst_run_en", run_en, 1);

      // ---------------- randomized command stream ----------------
      rand_full = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(99) < 80) push(pool[$urandom_range(11)]);
         else push(8'($urandom_range(255)));
         repeat ($urandom_range(3)) cycle();
      end
      drain();
      check_eq("rand_run_en", run_en, m_run);
      check_eq("rand_up_down", up_down, m_ud);
      check_eq("rand_err_cnt", err_cnt, m_err);
      check_eq("rand_clears", clears_seen, m_clears);
      rand_full = 0;
      tx_full = 1'b0;

      // ---------------- error counter saturation ----------------
      for (int i = 0; i < 260; i++) push(8'($urandom_range(8'h80, 8'hFF)));
      drain();
      check_eq("sat_err_cnt", err_cnt, 8'hFF);
      w0 = writes;
      push(8'h7A);
      drain();
      check_eq("sat_still_replies", writes - w0, 1);
      check_eq("sat_err_hold", err_cnt, 8'hFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Absolute time limit so a stuck design cannot hang the run.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
